// File: rtl/alu_shift_sequencer_pkg.sv
// Shared definitions for the shift ALU sequencer: core configuration
// constants, the ALU command encoding, the sequencer state type and a
// command-classification helper.
package alu_shift_sequencer_pkg;

  localparam int CORE_XLEN                = 32;
  localparam int CORE_MAX_SHIFT_PER_CYCLE = 8;
  localparam int CORE_TAG_W               = 5;

  typedef enum logic [6:0] {
    c_ADD = 7'd0,
    c_SUB = 7'd1,
    c_AND = 7'd2,
    c_OR  = 7'd3,
    c_XOR = 7'd4,
    c_SLL = 7'd5,
    c_SRL = 7'd6,
    c_SRA = 7'd7,
    c_SLT = 7'd8
  } alu_commands_t;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } shift_state_t;

  typedef enum logic {
    SH_LEFT  = 1'b0,
    SH_RIGHT = 1'b1
  } shift_dir_t;

  // True for the commands this slot actually executes.
  function automatic logic is_shift_cmd(input alu_commands_t cmd);
    logic r;
    case (cmd)
      c_SLL, c_SRL, c_SRA: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_sequencer_step.sv
// Combinational narrow shifter used once per SHIFT cycle.
// Ports:
//   value   - running value to shift
//   step    - shift distance this cycle (0..MAX_SHIFT_PER_CYCLE)
//   dir     - SH_LEFT or SH_RIGHT
//   arith   - right shifts replicate bit XLEN-1 when set
//   shifted - shifted value
module alu_shift_step
  import alu_shift_sequencer_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int STEP_W = 4
) (
  input  logic [XLEN-1:0]   value,
  input  logic [STEP_W-1:0] step,
  input  shift_dir_t        dir,
  input  logic              arith,
  output logic [XLEN-1:0]   shifted
);

  // Select left, arithmetic-right or logical-right shift.
  always_comb begin
    shifted = value;
    if (dir == SH_LEFT) begin
      shifted = value << step;
    end else if (arith) begin
      shifted = $unsigned($signed(value) >>> step);
    end else begin
      shifted = value >> step;
    end
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle sequencer for SLL/SRL/SRA. Shifts at most MAX_SHIFT_PER_CYCLE
// bits per cycle using one narrow shifter; non-shift commands complete
// immediately with the operand passed through and out_err set.
// Ports:
//   clk, rst (sync, active-high), flush (abort in-flight op)
//   in_valid/in_ready, in_cmd, in_a (value), in_b (shift amount), in_tag
//   out_valid/out_ready, out_result, out_tag, out_err
//   busy - sequencer not idle
// All outputs are registered.
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
#(
  parameter int XLEN                = CORE_XLEN,
  parameter int MAX_SHIFT_PER_CYCLE = CORE_MAX_SHIFT_PER_CYCLE,
  parameter int TAG_W               = CORE_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_commands_t     in_cmd,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int REM_W   = SHAMT_W + 1;
  localparam int STEP_W  = $clog2(MAX_SHIFT_PER_CYCLE + 1);
  localparam logic [REM_W-1:0] MAX_REM = REM_W'(MAX_SHIFT_PER_CYCLE);

  shift_state_t       state_r;
  logic [XLEN-1:0]    value_r;
  logic [REM_W-1:0]   rem_r;
  alu_commands_t      cmd_r;
  logic [TAG_W-1:0]   tag_r;

  logic [STEP_W-1:0]  step_s;
  logic               last_step_s;
  shift_dir_t         dir_s;
  logic               arith_s;
  logic [XLEN-1:0]    shifted_s;
  logic [SHAMT_W-1:0] in_shamt_s;

  assign in_shamt_s = in_b[SHAMT_W-1:0];

  // Clamp the per-cycle step so the remaining count never underflows.
  always_comb begin
    step_s      = {STEP_W{1'b0}};
    last_step_s = 1'b0;
    if (rem_r > MAX_REM) begin
      step_s      = STEP_W'(MAX_SHIFT_PER_CYCLE);
      last_step_s = 1'b0;
    end else begin
      step_s      = STEP_W'(rem_r);
      last_step_s = 1'b1;
    end
  end

  // Shift direction and fill come from the latched command.
  always_comb begin
    dir_s   = SH_RIGHT;
    arith_s = 1'b0;
    if (cmd_r == c_SLL) begin
      dir_s   = SH_LEFT;
      arith_s = 1'b0;
    end else begin
      dir_s   = SH_RIGHT;
      arith_s = (cmd_r == c_SRA);
    end
  end

  alu_shift_step #(
    .XLEN   (XLEN),
    .STEP_W (STEP_W)
  ) u_step (
    .value   (value_r),
    .step    (step_s),
    .dir     (dir_s),
    .arith   (arith_s),
    .shifted (shifted_s)
  );

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SH_IDLE;
      value_r    <= {XLEN{1'b0}};
      rem_r      <= {REM_W{1'b0}};
      cmd_r      <= c_ADD;
      tag_r      <= {TAG_W{1'b0}};
      out_valid  <= 1'b0;
      out_result <= {XLEN{1'b0}};
      out_tag    <= {TAG_W{1'b0}};
      out_err    <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      // Flush beats any accept or out handshake in the same cycle.
      state_r   <= SH_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        SH_IDLE: begin
          if (in_valid) begin
            value_r  <= in_a;
            rem_r    <= {1'b0, in_shamt_s};
            cmd_r    <= in_cmd;
            tag_r    <= in_tag;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (is_shift_cmd(in_cmd) && (in_shamt_s != {SHAMT_W{1'b0}})) begin
              state_r <= SH_SHIFT;
            end else begin
              state_r    <= SH_DONE;
              out_valid  <= 1'b1;
              out_result <= in_a;
              out_tag    <= in_tag;
              out_err    <= ~is_shift_cmd(in_cmd);
            end
          end else begin
            state_r <= SH_IDLE;
          end
        end
        SH_SHIFT: begin
          value_r <= shifted_s;
          rem_r   <= rem_r - REM_W'(step_s);
          if (last_step_s) begin
            state_r    <= SH_DONE;
            out_valid  <= 1'b1;
            out_result <= shifted_s;
            out_tag    <= tag_r;
            out_err    <= 1'b0;
          end else begin
            state_r <= SH_SHIFT;
          end
        end
        SH_DONE: begin
          // in_ready returns only after the handshake edge, so no re-accept here.
          if (out_ready) begin
            state_r   <= SH_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_r <= SH_DONE;
          end
        end
        default: begin
          state_r   <= SH_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed self-checking bench for alu_shift_sequencer with a result scoreboard.
module tb_alu_shift_sequencer;
  import alu_shift_sequencer_pkg::*;

  localparam int XLEN  = 32;
  localparam int MAXS  = 8;
  localparam int TAG_W = 5;

  typedef struct {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  alu_commands_t     in_cmd = c_ADD;
  logic [XLEN-1:0]   in_a = '0;
  logic [XLEN-1:0]   in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XLEN-1:0]   out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic              busy;

  exp_t sb[$];
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;

  alu_shift_sequencer #(
    .XLEN(XLEN), .MAX_SHIFT_PER_CYCLE(MAXS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference model: full-width shift in one go, latency from step count.
  function automatic exp_t model(input alu_commands_t cmd, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    int sh;
    sh = int'(b[4:0]);
    e.tag = tag;
    e.err = 1'b0;
    e.lat = 1 + (sh + MAXS - 1) / MAXS;
    case (cmd)
      c_SLL:   e.result = a << sh;
      c_SRL:   e.result = a >> sh;
      c_SRA:   e.result = $unsigned($signed(a) >>> sh);
      default: begin e.result = a; e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  // Called just after a negedge; returns 1ns after the accept edge.
  task automatic issue(input alu_commands_t cmd, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_cmd = cmd; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(model(cmd, a, b, tag));
  endtask

  task automatic wait_result();
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("out_valid_seen", {31'd0, seen}, 32'd1);
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (seen && sb.size() > 0) begin
      last_e = sb.pop_front();
      chk("latency", 32'(lat), 32'(last_e.lat));
      chk("result", out_result, last_e.result);
      chk("tag", {27'd0, out_tag}, {27'd0, last_e.tag});
      chk("err", {31'd0, out_err}, {31'd0, last_e.err});
      chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    end
  endtask

  // With out_ready high the handshake completes at the next edge.
  task automatic after_handshake();
    @(negedge clk);
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op(input alu_commands_t cmd, input logic [XLEN-1:0] a,
                    input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    issue(cmd, a, b, tag);
    wait_result();
    after_handshake();
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({pfx, "_out_result"}, out_result, 32'd0);
    chk({pfx, "_out_tag"}, {27'd0, out_tag}, 32'd0);
    chk({pfx, "_out_err"}, {31'd0, out_err}, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Main function, boundary shift amounts and a non-shift command
    op(c_SLL, 32'h0000_0001, 32'd31, 5'd3);
    op(c_SRA, 32'h8000_0000, 32'h0000_0024, 5'd7);
    op(c_SRL, 32'hF000_000F, 32'd0, 5'd1);
    op(c_ADD, 32'h0000_1234, 32'd5, 5'd2);
    op(c_SRA, 32'h8000_0001, 32'd31, 5'd30);
    op(c_SRL, 32'hDEAD_BEEF, 32'd8, 5'd17);
    op(c_SLL, 32'hDEAD_BEEF, 32'hFFFF_FFF1, 5'd31);
    op(c_SRA, 32'h7000_0000, 32'd9, 5'd4);

    // Writeback stall: outputs hold, in_ready stays low
    out_ready = 1'b0;
    issue(c_SLL, 32'h0000_0005, 32'd16, 5'd9);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_result", out_result, last_e.result);
      chk("stall_tag", {27'd0, out_tag}, {27'd0, last_e.tag});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    after_handshake();
    op(c_SRL, 32'h8000_0000, 32'd9, 5'd11);

    // Flush during the second SHIFT cycle drops the op
    issue(c_SLL, 32'h0000_0001, 32'd20, 5'd12);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    // Flush with a request in IDLE: nothing accepted
    in_cmd = c_SRL; in_a = 32'h1111_1111; in_b = 32'd0; in_tag = 5'd5;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end

    // Reset during SHIFT returns everything to reset values
    issue(c_SLL, 32'h0000_0003, 32'd31, 5'd21);
    void'(sb.pop_back());
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Recovery after reset
    op(c_SRA, 32'hF0F0_0000, 32'd12, 5'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
